// File: rtl/gan_seq_ctrl.sv
// gan_seq_ctrl: time-multiplexed sequencer for the 8-layer 4-2-1-1-1-2-4-4 GAN
// network. A single 6x32 multiply-accumulate unit walks every weight in
// layer-major order, one weight per cycle. Each neuron gets a write-back cycle
// that adds the bias and applies ReLU. Activations ping-pong between two
// 4-lane banks.
module gan_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [5:0]  cfg_wdata,
  input  logic [5:0]  x1,
  input  logic [5:0]  x2,
  input  logic [5:0]  x3,
  input  logic [5:0]  x4,
  output logic [31:0] f1,
  output logic [31:0] f2,
  output logic [31:0] f3,
  output logic [31:0] f4
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [72:0][5:0]      param_q, param_d;
  logic [1:0][3:0][31:0] bank_q, bank_d;
  logic                  bank_sel_q, bank_sel_d;
  logic [31:0]           acc_q, acc_d;
  logic [6:0]            ptr_q, ptr_d;
  logic [1:0]            in_idx_q, in_idx_d;
  logic [1:0]            out_idx_q, out_idx_d;
  logic [2:0]            layer_q, layer_d;
  logic [3:0][31:0]      f_q, f_d;

  logic [1:0]  last_in;
  logic [1:0]  last_out;
  logic        out_bank;
  logic        cfg_ok;
  logic [5:0]  param_rd;
  logic [31:0] param_ext;
  logic [31:0] act_in;
  logic [31:0] mac_sum;
  logic [31:0] wb_sum;
  logic [31:0] relu_y;

  // Layer geometry: index of the last input lane and last output neuron.
  always_comb begin
    last_in  = 2'd0;
    last_out = 2'd0;
    case (layer_q)
      3'd0:    begin last_in = 2'd3; last_out = 2'd3; end
      3'd1:    begin last_in = 2'd3; last_out = 2'd1; end
      3'd2:    begin last_in = 2'd1; last_out = 2'd0; end
      3'd3:    begin last_in = 2'd0; last_out = 2'd0; end
      3'd4:    begin last_in = 2'd0; last_out = 2'd0; end
      3'd5:    begin last_in = 2'd0; last_out = 2'd1; end
      3'd6:    begin last_in = 2'd1; last_out = 2'd3; end
      default: begin last_in = 2'd3; last_out = 2'd3; end
    endcase
  end

  // Shared arithmetic: combinational param read, MAC sum, bias add and ReLU.
  // All sums wrap modulo 2^32.
  always_comb begin
    out_bank  = ~bank_sel_q;
    param_rd  = param_q[ptr_q];
    param_ext = {{26{param_rd[5]}}, param_rd};
    act_in    = bank_q[bank_sel_q][in_idx_q];
    mac_sum   = acc_q + act_in * param_ext;
    wb_sum    = acc_q + param_ext;
    relu_y    = wb_sum[31] ? 32'd0 : wb_sum;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_MAC;
      S_MAC:  if (in_idx_q == last_in) state_d = S_WB;
      S_WB: begin
        if ((out_idx_q == last_out) && (layer_q == 3'd7)) state_d = S_DONE;
        else                                             state_d = S_MAC;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: busy covers the compute states only, done is the DONE state.
  always_comb begin
    busy = (state_q == S_MAC) || (state_q == S_WB);
    done = (state_q == S_DONE);
  end

  // Datapath next values: config writes while not computing, run start,
  // MAC stepping and neuron write-back with layer/bank advance.
  always_comb begin
    param_d    = param_q;
    bank_d     = bank_q;
    bank_sel_d = bank_sel_q;
    acc_d      = acc_q;
    ptr_d      = ptr_q;
    in_idx_d   = in_idx_q;
    out_idx_d  = out_idx_q;
    layer_d    = layer_q;
    f_d        = f_q;

    cfg_ok = cfg_we && !busy && (cfg_addr < 7'd73);
    if (cfg_ok) param_d[cfg_addr] = cfg_wdata;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          bank_d[0][0] = {{26{x1[5]}}, x1};
          bank_d[0][1] = {{26{x2[5]}}, x2};
          bank_d[0][2] = {{26{x3[5]}}, x3};
          bank_d[0][3] = {{26{x4[5]}}, x4};
          bank_sel_d   = 1'b0;
          acc_d        = 32'd0;
          ptr_d        = 7'd0;
          in_idx_d     = 2'd0;
          out_idx_d    = 2'd0;
          layer_d      = 3'd0;
        end
      end
      S_MAC: begin
        acc_d    = mac_sum;
        ptr_d    = ptr_q + 7'd1;
        in_idx_d = (in_idx_q == last_in) ? 2'd0 : in_idx_q + 2'd1;
      end
      S_WB: begin
        acc_d                      = 32'd0;
        ptr_d                      = ptr_q + 7'd1;
        bank_d[out_bank][out_idx_q] = relu_y;
        if (out_idx_q == last_out) begin
          out_idx_d = 2'd0;
          if (layer_q == 3'd7) begin
            f_d[0] = bank_q[out_bank][0];
            f_d[1] = bank_q[out_bank][1];
            f_d[2] = bank_q[out_bank][2];
            f_d[3] = relu_y;
          end else begin
            bank_sel_d = out_bank;
            layer_d    = layer_q + 3'd1;
          end
        end else begin
          out_idx_d = out_idx_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears the store, banks and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      param_q    <= '0;
      bank_q     <= '0;
      bank_sel_q <= 1'b0;
      acc_q      <= 32'd0;
      ptr_q      <= 7'd0;
      in_idx_q   <= 2'd0;
      out_idx_q  <= 2'd0;
      layer_q    <= 3'd0;
      f_q        <= '0;
    end else begin
      param_q    <= param_d;
      bank_q     <= bank_d;
      bank_sel_q <= bank_sel_d;
      acc_q      <= acc_d;
      ptr_q      <= ptr_d;
      in_idx_q   <= in_idx_d;
      out_idx_q  <= out_idx_d;
      layer_q    <= layer_d;
      f_q        <= f_d;
    end
  end

  assign f1 = f_q[0];
  assign f2 = f_q[1];
  assign f3 = f_q[2];
  assign f4 = f_q[3];

endmodule
